// File: rtl/command_parse_and_encapsulate_pcb_stat_pkg.sv
// Register map and status field positions shared by the PCB status register block.
package pcb_reg_pkg;

    localparam int unsigned PCB_ADDR_FREE  = 0;
    localparam int unsigned PCB_ADDR_WM    = 1;
    localparam int unsigned PCB_ADDR_THR   = 2;
    localparam int unsigned PCB_ADDR_ALARM = 3;
    localparam int unsigned PCB_NUM_REGS   = 4;

    // Layout of the alarm status register.
    localparam int unsigned ALARM_STICKY_BIT = 0;
    localparam int unsigned ALARM_CNT_LSB    = 16;

    typedef enum logic [1:0] {
        RegFree  = 2'(PCB_ADDR_FREE),
        RegWm    = 2'(PCB_ADDR_WM),
        RegThr   = 2'(PCB_ADDR_THR),
        RegAlarm = 2'(PCB_ADDR_ALARM)
    } pcb_reg_e;

endpackage

// File: rtl/command_parse_and_encapsulate_pcb_stat_if.sv
// Config-bus command/response bundle between the command parser and the PCB status block.
interface command_parse_and_encapsulate_pcb_stat_if #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] iv_addr;
    logic              i_addr_fixed;
    logic [DATA_W-1:0] iv_wdata;
    logic              i_wr_pcb;
    logic              i_rd_pcb;
    logic              o_wr_pcb;
    logic [ADDR_W-1:0] ov_addr_pcb;
    logic              o_addr_fixed_pcb;
    logic [DATA_W-1:0] ov_rdata_pcb;

    modport master (
        output iv_addr, i_addr_fixed, iv_wdata, i_wr_pcb, i_rd_pcb,
        input  o_wr_pcb, ov_addr_pcb, o_addr_fixed_pcb, ov_rdata_pcb
    );

    modport slave (
        input  iv_addr, i_addr_fixed, iv_wdata, i_wr_pcb, i_rd_pcb,
        output o_wr_pcb, ov_addr_pcb, o_addr_fixed_pcb, ov_rdata_pcb
    );
endinterface

// File: rtl/command_parse_and_encapsulate_pcb_stat_monitor.sv
// Free-bufid monitor: low watermark tracking, alarm edge detection and a sticky,
// saturating alarm event counter.
module pcb_free_monitor #(
    parameter int unsigned BUFID_W = 9,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [BUFID_W-1:0] free_i,
    input  logic [BUFID_W-1:0] thr_i,
    input  logic               rearm_i,
    input  logic               clr_i,
    output logic [BUFID_W-1:0] wm_o,
    output logic               wm_valid_o,
    output logic               alarm_o,
    output logic               sticky_o,
    output logic [CNT_W-1:0]   alarm_cnt_o
);
    logic [BUFID_W-1:0] wm_q, wm_d;
    logic               wm_valid_q, wm_valid_d;
    logic               alarm_q;
    logic               alarm;
    logic               rise;
    logic               sticky_q, sticky_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        wm_d       = wm_q;
        wm_valid_d = wm_valid_q;
        if (!wm_valid_q || rearm_i || (free_i < wm_q)) begin
            wm_d       = free_i;
            wm_valid_d = 1'b1;
        end
    end

    // A zero threshold can never be undercut, so the alarm stays quiet.
    assign alarm = (free_i < thr_i);
    assign rise  = alarm & ~alarm_q;

    // A new alarm event beats a same-cycle clear: it restarts the count at one.
    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (rise) begin
            sticky_d = 1'b1;
            if (clr_i) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (clr_i) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wm_q       <= '0;
            wm_valid_q <= 1'b0;
            alarm_q    <= 1'b0;
            sticky_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            wm_q       <= wm_d;
            wm_valid_q <= wm_valid_d;
            alarm_q    <= alarm;
            sticky_q   <= sticky_d;
            cnt_q      <= cnt_d;
        end
    end

    assign wm_o        = wm_q;
    assign wm_valid_o  = wm_valid_q;
    assign alarm_o     = alarm_q;
    assign sticky_o    = sticky_q;
    assign alarm_cnt_o = cnt_q;

endmodule

// File: rtl/command_parse_and_encapsulate_pcb_stat.sv
// PCB status register front end: decodes config-bus reads/writes to a four-entry register
// file and returns each read as a single registered response beat.
module command_parse_and_encapsulate_pcb_stat
    import pcb_reg_pkg::*;
#(
    parameter int unsigned BUFID_W = 9,
    parameter int unsigned ADDR_W  = 19,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned THR_RST = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic [BUFID_W-1:0]                     iv_free_pkt_bufid_num,
    command_parse_and_encapsulate_pcb_stat_if.slave cmd,
    output logic                                   o_free_alarm
);
    logic               addr_hit;
    pcb_reg_e           reg_sel;
    logic               wr_hit;
    logic               rd_hit;
    logic               rearm;
    logic               clr;
    logic [BUFID_W-1:0] thr_q, thr_d;
    logic [BUFID_W-1:0] wm;
    logic               wm_valid;
    logic               sticky;
    logic [CNT_W-1:0]   alarm_cnt;
    logic [DATA_W-1:0]  rd_data;

    logic               rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0]  rsp_addr_q, rsp_addr_d;
    logic               rsp_fixed_q, rsp_fixed_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

    logic               unused_wdata;

    assign addr_hit = cmd.i_addr_fixed && (cmd.iv_addr < ADDR_W'(PCB_NUM_REGS));
    assign reg_sel  = pcb_reg_e'(cmd.iv_addr[1:0]);
    assign wr_hit   = cmd.i_wr_pcb & addr_hit;
    // A write in the same cycle takes priority and swallows the read.
    assign rd_hit   = cmd.i_rd_pcb & ~cmd.i_wr_pcb & addr_hit;
    assign rearm    = wr_hit && (reg_sel == RegWm);
    assign clr      = wr_hit && (reg_sel == RegAlarm) && cmd.iv_wdata[ALARM_STICKY_BIT];

    assign unused_wdata = ^cmd.iv_wdata;

    always_comb begin
        thr_d = thr_q;
        if (wr_hit && (reg_sel == RegThr)) begin
            thr_d = cmd.iv_wdata[BUFID_W-1:0];
        end
    end

    pcb_free_monitor #(
        .BUFID_W (BUFID_W),
        .CNT_W   (CNT_W)
    ) u_monitor (
        .clk_i       (i_clk),
        .rst_i       (i_rst),
        .free_i      (iv_free_pkt_bufid_num),
        .thr_i       (thr_q),
        .rearm_i     (rearm),
        .clr_i       (clr),
        .wm_o        (wm),
        .wm_valid_o  (wm_valid),
        .alarm_o     (o_free_alarm),
        .sticky_o    (sticky),
        .alarm_cnt_o (alarm_cnt)
    );

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            RegFree: rd_data = DATA_W'(iv_free_pkt_bufid_num);
            RegWm:   rd_data = wm_valid ? DATA_W'(wm) : DATA_W'(iv_free_pkt_bufid_num);
            RegThr:  rd_data = DATA_W'(thr_q);
            RegAlarm: begin
                rd_data[ALARM_STICKY_BIT]         = sticky;
                rd_data[ALARM_CNT_LSB +: CNT_W]   = alarm_cnt;
            end
            default: rd_data = '0;
        endcase
    end

    // Response fields are zero whenever no beat is issued; nothing is held over.
    always_comb begin
        rsp_valid_d = rd_hit;
        rsp_fixed_d = rd_hit;
        rsp_addr_d  = rd_hit ? cmd.iv_addr : '0;
        rsp_data_d  = rd_hit ? rd_data : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            thr_q       <= BUFID_W'(THR_RST);
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_fixed_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            thr_q       <= thr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_fixed_q <= rsp_fixed_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign cmd.o_wr_pcb         = rsp_valid_q;
    assign cmd.ov_addr_pcb      = rsp_addr_q;
    assign cmd.o_addr_fixed_pcb = rsp_fixed_q;
    assign cmd.ov_rdata_pcb     = rsp_data_q;

endmodule

// File: tb/tb_command_parse_and_encapsulate_pcb_stat.sv
// Directed bench for the PCB status register block; counter width is reduced so that
// saturation is reachable in a short run.
module tb_command_parse_and_encapsulate_pcb_stat;

    localparam int unsigned BUFID_W = 9;
    localparam int unsigned ADDR_W  = 19;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned THR_RST = 16;
    localparam int unsigned CNT_W   = 4;

    logic               clk;
    logic               rst;
    logic [BUFID_W-1:0] free;
    logic               alarm;
    int                 n_total;
    int                 n_bad;

    command_parse_and_encapsulate_pcb_stat_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    command_parse_and_encapsulate_pcb_stat #(
        .BUFID_W (BUFID_W),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .THR_RST (THR_RST),
        .CNT_W   (CNT_W)
    ) dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .iv_free_pkt_bufid_num (free),
        .cmd                   (bus),
        .o_free_alarm          (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic [31:0] a,
                             input logic [31:0] d);
        check_eq({tag, ".valid"}, 32'(bus.o_wr_pcb), 32'(v));
        check_eq({tag, ".fixed"}, 32'(bus.o_addr_fixed_pcb), 32'(v));
        check_eq({tag, ".addr"}, 32'(bus.ov_addr_pcb), a);
        check_eq({tag, ".data"}, bus.ov_rdata_pcb, d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.i_rd_pcb     = 1'b0;
        bus.i_wr_pcb     = 1'b0;
        bus.i_addr_fixed = 1'b0;
        bus.iv_addr      = '0;
        bus.iv_wdata     = '0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic fx);
        bus.iv_addr      = a;
        bus.i_addr_fixed = fx;
        bus.i_rd_pcb     = 1'b1;
        tick();
        idle_bus();
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.iv_addr      = a;
        bus.i_addr_fixed = 1'b1;
        bus.iv_wdata     = d;
        bus.i_wr_pcb     = 1'b1;
        tick();
        idle_bus();
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        idle_bus();
        rst  = 1'b1;
        free = 9'd200;

        // Reset with a read pending: no response may come out.
        bus.i_rd_pcb     = 1'b1;
        bus.i_addr_fixed = 1'b1;
        tick();
        tick();
        check_rsp("reset", 1'b0, 32'd0, 32'd0);
        check_eq("reset.alarm", 32'(alarm), 32'd0);
        idle_bus();
        rst = 1'b0;
        tick();

        // Free count read, then the response clears.
        rd(19'd0, 1'b1);
        check_rsp("rd_free", 1'b1, 32'd0, 32'd200);
        tick();
        check_rsp("rd_free_gap", 1'b0, 32'd0, 32'd0);

        // Watermark tracking and re-arm.
        free = 9'd200; tick();
        free = 9'd150; tick();
        free = 9'd180; tick();
        rd(19'd1, 1'b1);
        check_rsp("wm_low", 1'b1, 32'd1, 32'd150);
        wr(19'd1, 32'hdead_beef);
        rd(19'd1, 1'b1);
        check_rsp("wm_rearm", 1'b1, 32'd1, 32'd180);

        // Threshold write, alarm lag and event count.
        wr(19'd2, 32'd100);
        rd(19'd2, 1'b1);
        check_rsp("thr_raw", 1'b1, 32'd2, 32'd100);
        free = 9'd120; tick();
        check_eq("alarm_120", 32'(alarm), 32'd0);
        free = 9'd90; tick();
        check_eq("alarm_90", 32'(alarm), 32'd1);
        free = 9'd120; tick();
        check_eq("alarm_120b", 32'(alarm), 32'd0);
        free = 9'd80; tick();
        check_eq("alarm_80", 32'(alarm), 32'd1);
        rd(19'd3, 1'b1);
        check_rsp("alarm_cnt2", 1'b1, 32'd3, 32'h0002_0001);

        // Count up to all-ones, then one more event must not wrap.
        for (int i = 0; i < 13; i++) begin
            free = 9'd120; tick();
            free = 9'd80;  tick();
        end
        rd(19'd3, 1'b1);
        check_rsp("cnt_full", 1'b1, 32'd3, 32'h000f_0001);
        free = 9'd120; tick();
        free = 9'd80;  tick();
        rd(19'd3, 1'b1);
        check_rsp("cnt_sat", 1'b1, 32'd3, 32'h000f_0001);

        // Clear racing a new event: the event wins.
        free = 9'd120; tick();
        free = 9'd80;
        wr(19'd3, 32'd1);
        rd(19'd3, 1'b1);
        check_rsp("w1c_race", 1'b1, 32'd3, 32'h0001_0001);
        wr(19'd3, 32'd1);
        rd(19'd3, 1'b1);
        check_rsp("w1c", 1'b1, 32'd3, 32'd0);

        // Zero threshold never alarms.
        wr(19'd2, 32'd0);
        free = 9'd0; tick(); tick();
        check_eq("thr0_alarm", 32'(alarm), 32'd0);
        rd(19'd3, 1'b1);
        check_rsp("thr0_status", 1'b1, 32'd3, 32'd0);

        // Misses, dropped reads and ignored writes.
        free = 9'd200; tick();
        rd(19'd5, 1'b1);
        check_rsp("miss_addr5", 1'b0, 32'd0, 32'd0);
        rd(19'd0, 1'b0);
        check_rsp("miss_nonfixed", 1'b0, 32'd0, 32'd0);
        bus.iv_addr      = 19'd2;
        bus.i_addr_fixed = 1'b1;
        bus.iv_wdata     = 32'h55;
        bus.i_wr_pcb     = 1'b1;
        bus.i_rd_pcb     = 1'b1;
        tick();
        idle_bus();
        check_rsp("wr_rd_drop", 1'b0, 32'd0, 32'd0);
        rd(19'd2, 1'b1);
        check_rsp("thr_55", 1'b1, 32'd2, 32'h55);
        rd(19'd5, 1'b1);
        check_rsp("miss_after_hit", 1'b0, 32'd0, 32'd0);
        wr(19'd6, 32'h7);
        wr(19'd0, 32'h7);
        rd(19'd2, 1'b1);
        check_rsp("bad_wr_ignored", 1'b1, 32'd2, 32'h55);
        rd(19'd0, 1'b1);
        check_rsp("ro_free", 1'b1, 32'd0, 32'd200);

        // Back-to-back reads every cycle.
        bus.i_rd_pcb     = 1'b1;
        bus.i_addr_fixed = 1'b1;
        bus.iv_addr      = 19'd0; tick();
        check_rsp("b2b_0", 1'b1, 32'd0, 32'd200);
        bus.iv_addr      = 19'd2; tick();
        check_rsp("b2b_2", 1'b1, 32'd2, 32'h55);
        bus.iv_addr      = 19'd3; tick();
        check_rsp("b2b_3", 1'b1, 32'd3, 32'd0);

        // Reset during the second of two reads.
        bus.iv_addr = 19'd0; tick();
        check_rsp("rst_first", 1'b1, 32'd0, 32'd200);
        bus.iv_addr = 19'd2;
        rst = 1'b1;
        tick();
        check_rsp("rst_drop", 1'b0, 32'd0, 32'd0);
        idle_bus();
        rst  = 1'b0;
        free = 9'd55;
        rd(19'd1, 1'b1);
        check_rsp("wm_invalid", 1'b1, 32'd1, 32'd55);
        tick();
        check_rsp("post_rst_idle", 1'b0, 32'd0, 32'd0);
        rd(19'd2, 1'b1);
        check_rsp("thr_rst", 1'b1, 32'd2, 32'(THR_RST));
        free = 9'd60; tick();
        rd(19'd1, 1'b1);
        check_rsp("wm_after_rst", 1'b1, 32'd1, 32'd55);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/command_parse_and_encapsulate_pcb_stat.md
Name: command_parse_and_encapsulate_pcb_stat

Overview:
- Parametrised successor to the PCB command parse/encapsulate block: a register-access front end for the packet centralized buffer (PCB).
- Exposes a small register file, not a single read-only word: current free bufid count, low watermark, programmable alarm threshold, and sticky alarm status/counter.
- Sits between the config-bus command parser and PCB free-bufid management; answers reads with one registered response beat and accepts writes.

Parameters:
- BUFID_W, 9, width of iv_free_pkt_bufid_num.
- ADDR_W, 19, command address width.
- DATA_W, 32, command data width; must be >= 32.
- THR_RST, 16, reset value of the alarm threshold.
- CNT_W, 16, alarm event counter width; must be <= DATA_W-16.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- iv_free_pkt_bufid_num  in  BUFID_W  current free bufid count from PCB.
- iv_addr  in  ADDR_W  command address.
- i_addr_fixed  in  1  1 = fixed (register) address space.
- iv_wdata  in  DATA_W  write data.
- i_wr_pcb  in  1  write strobe, one cycle.
- i_rd_pcb  in  1  read strobe, one cycle.
- o_wr_pcb  out  1  read-response valid, one-cycle pulse.
- ov_addr_pcb  out  ADDR_W  echoed address of the response.
- o_addr_fixed_pcb  out  1  echoed fixed flag.
- ov_rdata_pcb  out  DATA_W  read data.
- o_free_alarm  out  1  level: free count below threshold.

Behaviour:
- Reset: every output is 0. Watermark reg = 0 and wm_valid = 0. Threshold = THR_RST. Sticky bit = 0, alarm count = 0, internal alarm_d = 0.
- Register map (fixed space only, i_addr_fixed = 1):
  - addr 0: free count, RO.
  - addr 1: low watermark, RO; a write of any data re-arms it.
  - addr 2: threshold[BUFID_W-1:0], RW.
  - addr 3: {alarm_cnt, zero pad, sticky}, with sticky at bit 0 and alarm_cnt at bits [16+CNT_W-1:16]. A write with wdata[0] = 1 clears both (W1C).
- Read: i_rd_pcb with a valid address gives, on the next edge, o_wr_pcb = 1, address and fixed flag echoed, and data zero-extended. Latency is 1 cycle, one response per request, back-to-back reads allowed every cycle.
- Read miss: non-fixed or address > 3 gives no response; all outputs return to 0 that cycle.
- No response cycle: o_wr_pcb, ov_addr_pcb, o_addr_fixed_pcb and ov_rdata_pcb are all 0. There is no hold.
- Write: i_wr_pcb with a valid address takes effect on the next edge and produces no response. Writes to RO addr 0, or to invalid addresses, are ignored.
- Simultaneous i_wr_pcb and i_rd_pcb: the write is performed and the read is dropped (no response).
- Read-after-write: a read in the cycle after a write returns the new value.
- Watermark, updated every cycle:
  - if !wm_valid, or a re-arm write, or free < wm: wm <= free and wm_valid <= 1.
  - Reading addr 1 while !wm_valid returns the current free count.
- Alarm:
  - alarm = (free < threshold); o_free_alarm = alarm, registered with 1-cycle lag.
  - Rising edge (alarm & !alarm_d): sticky <= 1 and alarm_cnt <= alarm_cnt + 1, saturating at all-ones.
  - Simultaneous W1C and rising edge: the event wins, giving sticky = 1 and cnt = 1.
  - Threshold = 0 means the alarm never fires.
- Reset asserted mid-operation: any pending response is dropped and all state returns to reset values on that edge.

Decomposition:
- Shared package pcb_reg_pkg holds:
  - address constants PCB_ADDR_FREE = 0, PCB_ADDR_WM = 1, PCB_ADDR_THR = 2, PCB_ADDR_ALARM = 3;
  - PCB_NUM_REGS = 4;
  - the ALARM status bit-position constants.
- One natural sub-module, pcb_free_monitor: holds the watermark, the alarm edge detect and the saturating counter, with clear/re-arm inputs.
- Decode and response encapsulation stay in the top module.

Test Plan:
- Reset, then free = 200, read addr 0 (fixed) -> next cycle o_wr_pcb = 1, addr 0, rdata = 200; the following cycle all outputs are 0.
- free sequence 200, 150, 180, then read addr 1 -> 150. Write addr 1 while free = 180, then read -> 180.
- Write addr 2 = 100. free goes 120 -> 90 -> 120 -> 80 -> o_free_alarm follows 1 cycle late; read addr 3 -> 0x0002_0001.
- With cnt forced to 0xFFFF: another rising edge -> cnt stays 0xFFFF. W1C in the same cycle as a rising edge -> read gives 0x0001_0001.
- Read addr 5, a non-fixed addr 0 read, and a read simultaneous with a write to addr 2 -> no o_wr_pcb pulse. A subsequent read of addr 2 returns the written value.
- Back-to-back reads of addr 0, 2, 3 on consecutive cycles -> three consecutive response pulses with correct echoed addresses. Reset asserted during the second read -> no further responses, threshold reads THR_RST afterward.
